// File: rtl/phase_shift_applier_pkg.sv
// Shared phase types and constants for the LLRF NCO phase path.
package llrf_phase_pkg;

  localparam int unsigned PHASE_W_DEFAULT = 32;

  typedef logic        [PHASE_W_DEFAULT-1:0] phase_t;
  typedef logic signed [PHASE_W_DEFAULT-1:0] sphase_t;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_t;

  localparam phase_t PHASE_90  = 32'h4000_0000;
  localparam phase_t PHASE_180 = 32'h8000_0000;

endpackage

// File: rtl/phase_shift_applier_nco.sv
// Free-running NCO phase accumulator: acc advances by freq on every clock.
module nco_phase_acc #(
  parameter int unsigned PHASE_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PHASE_W-1:0] freq,
  output logic [PHASE_W-1:0] acc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc <= '0;
    else       acc <= acc + freq;
  end

endmodule

// File: rtl/phase_shift_applier.sv
// NCO phase output with a slew-limited phase offset: a requested shift is
// ramped into the offset by at most max_step per clock.
module phase_shift_applier
  import llrf_phase_pkg::*;
#(
  parameter int unsigned PHASE_W = PHASE_W_DEFAULT,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PHASE_W-1:0] freq,
  input  logic               apply,
  input  logic [PHASE_W-1:0] phase_shift,
  input  logic [PHASE_W-1:0] max_step,
  output logic [PHASE_W-1:0] phase_out,
  output logic               busy,
  output logic               done,
  output logic               apply_dropped,
  output logic [CNT_W-1:0]   ramp_cycles,
  output logic [PHASE_W-1:0] remaining
);

  state_t             state, state_d;
  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] offset, offset_d;
  logic [PHASE_W-1:0] remaining_d;
  logic [PHASE_W-1:0] step_q, step_d;
  logic [CNT_W-1:0]   cnt_d;
  logic               done_d, dropped_d;
  logic [PHASE_W:0]   mag;
  logic               finish;

  nco_phase_acc #(.PHASE_W(PHASE_W)) u_acc (
    .clk   (clk),
    .reset (reset),
    .freq  (freq),
    .acc   (acc)
  );

  // One extra bit so that the most negative shift has a representable magnitude.
  always_comb begin
    mag    = remaining[PHASE_W-1] ? ({1'b0, ~remaining} + (PHASE_W+1)'(1))
                                  : {1'b0, remaining};
    finish = (step_q == '0) || (mag <= {1'b0, step_q});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (apply && (phase_shift != '0)) state_d = RAMP;
      RAMP:    if (finish) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    offset_d    = offset;
    remaining_d = remaining;
    step_d      = step_q;
    cnt_d       = ramp_cycles;
    done_d      = 1'b0;
    dropped_d   = 1'b0;
    case (state)
      IDLE: begin
        if (apply) begin
          cnt_d = '0;
          if (phase_shift != '0) begin
            remaining_d = phase_shift;
            step_d      = max_step;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RAMP: begin
        dropped_d = apply;
        if (ramp_cycles != '1) cnt_d = ramp_cycles + CNT_W'(1);
        if (finish) begin
          offset_d    = offset + remaining;
          remaining_d = '0;
          done_d      = 1'b1;
        end else if (remaining[PHASE_W-1]) begin
          offset_d    = offset - step_q;
          remaining_d = remaining + step_q;
        end else begin
          offset_d    = offset + step_q;
          remaining_d = remaining - step_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      offset        <= '0;
      remaining     <= '0;
      step_q        <= '0;
      ramp_cycles   <= '0;
      phase_out     <= '0;
      done          <= 1'b0;
      apply_dropped <= 1'b0;
    end else begin
      offset        <= offset_d;
      remaining     <= remaining_d;
      step_q        <= step_d;
      ramp_cycles   <= cnt_d;
      phase_out     <= acc + offset;
      done          <= done_d;
      apply_dropped <= dropped_d;
    end
  end

  assign busy = (state == RAMP);

endmodule

// File: tb/tb_phase_shift_applier.sv
// Randomised and directed checks of phase_shift_applier against a ramp model.
module tb_phase_shift_applier;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] freq;
  logic        apply;
  logic [31:0] phase_shift;
  logic [31:0] max_step;
  logic [31:0] phase_out;
  logic        busy;
  logic        done;
  logic        apply_dropped;
  logic [15:0] ramp_cycles;
  logic [31:0] remaining;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: ramp described as j steps of size m_stp into a shift of magnitude m_mag.
  logic [31:0] m_acc, m_base;
  logic        m_active, m_neg;
  longint      m_mag, m_stp, m_j, m_k;
  logic [31:0] e_phase, e_rem;
  logic        e_busy, e_done, e_drop;
  logic [15:0] e_cnt;

  phase_shift_applier #(.PHASE_W(32), .CNT_W(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .freq          (freq),
    .apply         (apply),
    .phase_shift   (phase_shift),
    .max_step      (max_step),
    .phase_out     (phase_out),
    .busy          (busy),
    .done          (done),
    .apply_dropped (apply_dropped),
    .ramp_cycles   (ramp_cycles),
    .remaining     (remaining)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic longint applied();
    longint a;
    a = m_stp * m_j;
    if (a > m_mag) a = m_mag;
    return a;
  endfunction

  function automatic logic [31:0] offset_now();
    longint a;
    if (!m_active) return m_base;
    a = applied();
    return m_base + 32'(m_neg ? -a : a);
  endfunction

  task automatic model_reset();
    m_acc = '0; m_base = '0; m_active = 1'b0; m_neg = 1'b0;
    m_mag = 0; m_stp = 0; m_j = 0; m_k = 0;
    e_phase = '0; e_rem = '0; e_busy = 1'b0; e_done = 1'b0; e_drop = 1'b0; e_cnt = '0;
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic model_edge();
    e_phase = m_acc + offset_now();
    m_acc   = m_acc + freq;
    e_done  = 1'b0;
    e_drop  = 1'b0;
    if (!m_active) begin
      if (apply) begin
        e_cnt = '0;
        if (phase_shift == 32'h0) e_done = 1'b1;
        else begin
          m_active = 1'b1;
          m_j      = 0;
          m_neg    = phase_shift[31];
          m_mag    = m_neg ? (64'h1_0000_0000 - longint'(phase_shift)) : longint'(phase_shift);
          m_stp    = longint'(max_step);
          m_k      = (m_stp == 0) ? 1 : (m_mag + m_stp - 1) / m_stp;
        end
      end
    end else begin
      if (apply) e_drop = 1'b1;
      m_j++;
      if (e_cnt != 16'hFFFF) e_cnt++;
      if (m_j == m_k) begin
        m_base   = m_base + 32'(m_neg ? -m_mag : m_mag);
        m_active = 1'b0;
        e_done   = 1'b1;
      end
    end
    e_busy = m_active;
    e_rem  = m_active ? 32'(m_neg ? -(m_mag - applied()) : (m_mag - applied())) : 32'h0;
  endtask

  task automatic check_all(input string pfx);
    check({pfx, ".phase_out"},     phase_out,            e_phase);
    check({pfx, ".busy"},          32'(busy),            32'(e_busy));
    check({pfx, ".done"},          32'(done),            32'(e_done));
    check({pfx, ".apply_dropped"}, 32'(apply_dropped),   32'(e_drop));
    check({pfx, ".ramp_cycles"},   32'(ramp_cycles),     32'(e_cnt));
    check({pfx, ".remaining"},     remaining,            e_rem);
  endtask

  task automatic cyc(input string pfx, input logic a, input logic [31:0] sh, input logic [31:0] ms);
    apply       = a;
    phase_shift = sh;
    max_step    = ms;
    model_edge();
    @(posedge clk);
    #1;
    apply = 1'b0;
    check_all(pfx);
  endtask

  task automatic idle_cycles(input string pfx, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc(pfx, 1'b0, 32'h0, 32'h0);
  endtask

  // Asserted between edges: outputs must clear without waiting for a clock.
  task automatic async_reset(input string pfx);
    reset = 1'b1;
    #1;
    model_reset();
    check_all(pfx);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] sh, ms;
    reset = 1'b1; freq = '0; apply = 1'b0; phase_shift = '0; max_step = '0;
    model_reset();
    #1;
    check_all("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    freq = 32'h0147_AE14;
    idle_cycles("free_run", 210);
    freq = '0;

    cyc("big_pos", 1'b1, 32'h8000_0000, 32'h1000_0000);
    idle_cycles("big_pos", 10);

    cyc("neg", 1'b1, 32'hF000_0000, 32'h0400_0000);
    idle_cycles("neg", 6);
    cyc("nondiv", 1'b1, 32'd5, 32'd2);
    idle_cycles("nondiv", 5);

    cyc("step0", 1'b1, 32'h4000_0000, 32'h0);
    idle_cycles("step0", 3);
    cyc("zero_shift", 1'b1, 32'h0, 32'h0);
    idle_cycles("zero_shift", 2);

    cyc("drop", 1'b1, 32'h8000_0000, 32'h1000_0000);
    idle_cycles("drop", 2);
    cyc("drop", 1'b1, 32'h1234_5678, 32'h0);
    idle_cycles("drop", 8);

    cyc("fin_edge", 1'b1, 32'd5, 32'd2);
    idle_cycles("fin_edge", 2);
    cyc("fin_edge", 1'b1, 32'd7, 32'd0);
    cyc("fin_edge", 1'b1, 32'd7, 32'd0);
    idle_cycles("fin_edge", 3);

    freq = 32'h0010_0000;
    cyc("mid_reset", 1'b1, 32'h8000_0000, 32'h1000_0000);
    idle_cycles("mid_reset", 3);
    async_reset("mid_reset.async");
    idle_cycles("mid_reset.after", 10);

    for (int unsigned i = 0; i < 600; i++) begin
      if (i % 50 == 0) freq = $urandom;
      if ($urandom_range(0, 249) == 0) async_reset("rand.reset");
      case ($urandom_range(0, 5))
        0:       sh = 32'h8000_0000;
        1:       sh = 32'h0;
        2:       sh = $urandom_range(0, 20) - 10;
        default: sh = $urandom;
      endcase
      ms = ($urandom_range(0, 7) == 0) ? 32'h0 : ($urandom >> $urandom_range(3, 10));
      if (sh[3:0] == 4'h3) ms = 32'd1;
      if (ms == 32'd1 && sh != 32'h0) sh = $urandom_range(1, 40);
      cyc("rand", ($urandom_range(0, 5) == 0), sh, ms);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
